// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   - Default geometry of the bank (WIDTH/DEPTH/ADDR_W).
//   - Arbiter FSM state encoding.
package reg_bank_arbiter_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR0  = 2'b01,
        ST_WR1  = 2'b10
    } state_e;

endpackage

// File: rtl/reg_bank_arbiter_reg_word.sv
// reg_word: WIDTH-bit register with synchronous active-low clear and
// write enable. Clear has priority over the write.
//   clk_i   rising-edge clock
//   clr_ni  synchronous clear, active-low
//   we_i    write enable
//   d_i     write data
//   q_o     registered value
module reg_word #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            word_q <= '0;
        end else if (we_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: register bank with one shared write port arbitrated
// round-robin between two requesters, plus a combinational read port.
//   clk          rising-edge clock
//   clr          synchronous reset, active-low
//   req0/addr0/data0, gnt0   requester 0 (ALU writeback)
//   req1/addr1/data1, gnt1   requester 1 (load/immediate)
//   rd_addr/rd_data          combinational read port (no write bypass)
//   busy                     high whenever a write cycle is in progress
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  data1,
    output logic              gnt1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              lp_q, lp_d;         // last served requester
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [WIDTH-1:0]  hold_data_q;
    logic              latch_en;
    logic              latch_sel1;         // 1: latch requester 1's operands
    logic              wr_active;
    logic [WIDTH-1:0]  bank_q [DEPTH];

    // Next-state logic. A requester currently in its WR cycle is never
    // re-eligible, so ties only arise from IDLE and are broken by ~lp.
    always_comb begin
        state_d    = state_q;
        lp_d       = lp_q;
        latch_en   = 1'b0;
        latch_sel1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    latch_en   = 1'b1;
                    latch_sel1 = ~lp_q;
                    state_d    = lp_q ? ST_WR0 : ST_WR1;
                end else if (req0) begin
                    latch_en = 1'b1;
                    state_d  = ST_WR0;
                end else if (req1) begin
                    latch_en   = 1'b1;
                    latch_sel1 = 1'b1;
                    state_d    = ST_WR1;
                end
            end
            ST_WR0: begin
                lp_d = 1'b0;
                if (req1) begin
                    latch_en   = 1'b1;
                    latch_sel1 = 1'b1;
                    state_d    = ST_WR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR1: begin
                lp_d = 1'b1;
                if (req0) begin
                    latch_en = 1'b1;
                    state_d  = ST_WR0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_addr_d = hold_addr_q;
        if (latch_en) begin
            hold_addr_d = latch_sel1 ? addr1 : addr0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            lp_q        <= 1'b1;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            lp_q        <= lp_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    reg_word #(.WIDTH(WIDTH)) u_hold_data (
        .clk_i  (clk),
        .clr_ni (clr),
        .we_i   (latch_en),
        .d_i    (latch_sel1 ? data1 : data0),
        .q_o    (hold_data_q)
    );

    assign wr_active = (state_q != ST_IDLE);

    // The clear on each word wins over the write, so a WR cycle that
    // coincides with reset is dropped.
    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk_i  (clk),
            .clr_ni (clr),
            .we_i   (wr_active && (hold_addr_q == ADDR_W'(i))),
            .d_i    (hold_data_q),
            .q_o    (bank_q[i])
        );
    end

    assign gnt0    = (state_q == ST_WR0);
    assign gnt1    = (state_q == ST_WR1);
    assign busy    = wr_active;
    assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       req0, req1;
    logic [1:0] addr0, addr1, rd_addr;
    logic [7:0] data0, data1, rd_data;
    logic       gnt0, gnt1, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk     (clk),
        .clr     (clr),
        .req0    (req0),
        .addr0   (addr0),
        .data0   (data0),
        .gnt0    (gnt0),
        .req1    (req1),
        .addr1   (addr1),
        .data1   (data1),
        .gnt1    (gnt1),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    typedef struct {
        logic       chk;
        logic       clr;
        logic       r0;
        logic [1:0] a0;
        logic [7:0] d0;
        logic       r1;
        logic [1:0] a1;
        logic [7:0] d1;
        logic [1:0] rd;
        logic       g0;
        logic       g1;
        logic       bz;
        logic [7:0] rdd;
    } vec_t;

    vec_t vecs[$];

    // Reference model: who is being served this cycle (0 none, 1 req0,
    // 2 req1), the last-served pointer, the latched write and the bank.
    int         m_srv;
    logic       m_lp;
    logic [1:0] m_ha;
    logic [7:0] m_hd;
    logic [7:0] m_bank [4];

    task automatic add(input logic ck, input logic c,
                       input logic r0, input logic [1:0] a0, input logic [7:0] d0,
                       input logic r1, input logic [1:0] a1, input logic [7:0] d1,
                       input logic [1:0] rd,
                       input logic g0, input logic g1, input logic bz,
                       input logic [7:0] rdd);
        vec_t v;
        v.chk = ck; v.clr = c;
        v.r0 = r0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.d1 = d1;
        v.rd = rd; v.g0 = g0; v.g1 = g1; v.bz = bz; v.rdd = rdd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge using the inputs just applied.
    task automatic model_edge();
        bit e0, e1;
        int nxt;
        if (!clr) begin
            m_srv = 0; m_lp = 1'b1; m_ha = '0; m_hd = '0;
            for (int i = 0; i < 4; i++) m_bank[i] = '0;
        end else begin
            if (m_srv != 0) begin
                m_bank[m_ha] = m_hd;
                m_lp = (m_srv == 2);
            end
            e0 = req0 && (m_srv != 1);
            e1 = req1 && (m_srv != 2);
            if (e0 && e1) nxt = m_lp ? 1 : 2;
            else if (e0)  nxt = 1;
            else if (e1)  nxt = 2;
            else          nxt = 0;
            if (nxt == 1) begin m_ha = addr0; m_hd = data0; end
            if (nxt == 2) begin m_ha = addr1; m_hd = data1; end
            m_srv = nxt;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clr = v.clr; req0 = v.r0; addr0 = v.a0; data0 = v.d0;
        req1 = v.r1; addr1 = v.a1; data1 = v.d1; rd_addr = v.rd;
        #1;
        if (v.chk) begin
            check($sformatf("vec%0d gnt0", idx), {7'b0, gnt0}, {7'b0, v.g0});
            check($sformatf("vec%0d gnt1", idx), {7'b0, gnt1}, {7'b0, v.g1});
            check($sformatf("vec%0d busy", idx), {7'b0, busy}, {7'b0, v.bz});
            check($sformatf("vec%0d rd_data", idx), rd_data, v.rdd);
        end
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        vec_t rv;
        clr = 1'b0; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        data0 = 0; data1 = 0; rd_addr = 0;
        m_srv = 0; m_lp = 1'b1; m_ha = '0; m_hd = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;

        // Reset state
        add(0,0, 0,0,8'h00, 0,0,8'h00, 0, 0,0,0,8'h00);
        add(1,0, 0,0,8'h00, 0,0,8'h00, 0, 0,0,0,8'h00);
        // Single request: gnt in N+1, new value in N+2
        add(1,1, 1,2,8'hA5, 0,0,8'h00, 2, 0,0,0,8'h00);
        add(1,1, 0,2,8'hA5, 0,0,8'h00, 2, 1,0,1,8'h00);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 2, 0,0,0,8'hA5);
        // Reset, then contention: requester 0 wins first
        add(1,0, 0,0,8'h00, 0,0,8'h00, 2, 0,0,0,8'hA5);
        add(1,1, 1,1,8'h11, 1,3,8'h33, 1, 0,0,0,8'h00);
        add(1,1, 0,1,8'h11, 1,3,8'h33, 1, 1,0,1,8'h00);
        add(1,1, 0,0,8'h00, 0,3,8'h33, 3, 0,1,1,8'h00);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 3, 0,0,0,8'h33);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h11);
        // Fairness: both held 8 cycles -> strict alternation
        for (int k = 0; k < 8; k++)
            add(1,1, 1,0,8'h01, 1,1,8'h02, 0,
                (k != 0) && (k % 2 == 1), (k != 0) && (k % 2 == 0), (k != 0),
                (k <= 1) ? 8'h00 : 8'h01);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 0, 0,1,1,8'h01);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h02);
        // Single held request: grant every other cycle, latched data written
        for (int k = 0; k < 6; k++)
            add(1,1, 0,0,8'h00, 1,2,8'hB1 + 8'(k), 2, 0, (k % 2 == 1), (k % 2 == 1),
                (k < 2) ? 8'h00 : ((k < 4) ? 8'hB1 : 8'hB3));
        add(1,1, 0,0,8'h00, 0,0,8'h00, 2, 0,0,0,8'hB5);
        // Same address back-to-back: F0 visible for exactly one cycle
        add(1,1, 1,0,8'hF0, 0,0,8'h00, 0, 0,0,0,8'h01);
        add(1,1, 0,0,8'hF0, 1,0,8'h0F, 0, 1,0,1,8'h01);
        add(1,1, 0,0,8'h00, 0,0,8'h0F, 0, 0,1,1,8'hF0);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 0, 0,0,0,8'h0F);
        // Reset mid-WR0: pending write dropped, bank cleared
        add(1,1, 1,3,8'h77, 0,0,8'h00, 3, 0,0,0,8'h33);
        add(1,0, 0,3,8'h77, 0,0,8'h00, 3, 1,0,1,8'h33);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 3, 0,0,0,8'h00);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 0, 0,0,0,8'h00);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 2, 0,0,0,8'h00);
        // Request during reset is arbitrated only after release
        add(1,0, 0,0,8'h00, 1,1,8'h99, 1, 0,0,0,8'h00);
        add(1,1, 0,0,8'h00, 1,1,8'h99, 1, 0,0,0,8'h00);
        add(1,1, 0,0,8'h00, 0,1,8'h99, 1, 0,1,1,8'h00);
        add(1,1, 0,0,8'h00, 0,0,8'h00, 1, 0,0,0,8'h99);

        foreach (vecs[i]) apply(vecs[i], i);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            clr     = ($urandom_range(0, 24) != 0);
            req0    = ($urandom_range(0, 2) != 0);
            req1    = ($urandom_range(0, 2) != 0);
            addr0   = 2'($urandom);
            addr1   = 2'($urandom);
            data0   = 8'($urandom);
            data1   = 8'($urandom);
            rd_addr = 2'($urandom);
            #1;
            check("rnd gnt0", {7'b0, gnt0}, {7'b0, (m_srv == 1)});
            check("rnd gnt1", {7'b0, gnt1}, {7'b0, (m_srv == 2)});
            check("rnd busy", {7'b0, busy}, {7'b0, (m_srv != 0)});
            check("rnd rd_data", rd_data, m_bank[rd_addr]);
            @(posedge clk);
            model_edge();
        end
        rv = vecs[0];
        rv = rv;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Write-port arbiter and storage for a small general-purpose register bank built from synchronous flip-flops. Two requesters (requester 0: ALU writeback; requester 1: load/immediate path) share a single write port under round-robin arbitration with a req/gnt handshake. A combinational read port serves the datapath. The block sits between the execute/memory stages and the operand-fetch logic of the processor.

## Interface
- WIDTH, 8, data bits per register
- DEPTH, 4, number of registers (power of two)
- ADDR_W, 2, log2(DEPTH)

- clk  in  1  rising-edge clock, sole clock domain
- clr  in  1  reset, synchronous, active-low; sampled on rising clk edge, overrides all other inputs
- req0  in  1  requester 0 write request; held high with addr0/data0 stable until gnt0
- addr0  in  ADDR_W  requester 0 target register
- data0  in  WIDTH  requester 0 write data
- gnt0  out  1  one-cycle grant; requester 0 write commits at the end of this cycle
- req1, addr1, data1, gnt1: same as above for requester 1
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  combinational read of bank[rd_addr]
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, WR0, WR1. Encode as registered state; gnt0 = (state==WR0), gnt1 = (state==WR1), busy = (state!=IDLE).
- Round-robin pointer lp (1 bit, last served). After reset lp=1, so requester 0 wins the first contention.
- IDLE: if only req0 -> WR0; if only req1 -> WR1; if both -> WR(~lp); if none -> stay IDLE. On the transition, latch the winner's addr/data into holding registers hold_addr/hold_data.
- WR0: write hold_data into bank[hold_addr] at the clock edge ending the cycle; set lp=0. req0 is ignored during this cycle. If req1 is high -> WR1 (latch addr1/data1), else -> IDLE.
- WR1: symmetric; set lp=1; req0 high -> WR0, else IDLE.
- Requester protocol: deassert req the cycle after seeing gnt, or keep it asserted to request another write. A held-high req is re-arbitrated only from IDLE or from the other requester's WR state, so each requester is granted at most once per two cycles under contention.
- Exactly one write per WR cycle. There are no simultaneous writes, so there are no same-address conflicts.
- Values on addrX/dataX are sampled only on the IDLE->WRx or WRy->WRx transition. Later changes before gnt are a protocol violation: the latched values are written.

## Timing
- Reset (clr=0 at edge): state=IDLE, lp=1, hold_addr=0, hold_data=0, all bank entries=0. gnt0=gnt1=busy=0 from the following cycle. A write in a WR cycle coinciding with clr=0 is discarded.
- Reset has priority over every FSM transition. Requests present during reset are not latched. They are arbitrated starting in the first cycle with clr=1.
- Latency: request first high in IDLE cycle N -> gnt in cycle N+1 -> new value on rd_data (rd_addr matching) in cycle N+2.
- Throughput: one write per cycle under continuous alternating contention (WR0<->WR1). A single requester gets one write per two cycles (WRx, IDLE, WRx...).
- No read-during-write bypass: during the gnt cycle, rd_data shows the old value.

## Structure
- Shared package: state encoding constants (ST_IDLE=2'b00, ST_WR0=2'b01, ST_WR1=2'b10), default WIDTH/DEPTH/ADDR_W.
- One sub-module, reg_word: a WIDTH-bit register with synchronous active-low clear and write enable. It is instantiated DEPTH times and once for the holding data register.
- Arbiter FSM, pointer and read mux live in reg_bank_arbiter itself.

## Test plan
- Reset: preload entries, assert clr=0 for one edge mid-WR0 -> all rd_data reads 0, gnt0=gnt1=busy=0, and the pending write is not committed.
- Single request: req0=1, addr0=2, data0=8'hA5 in IDLE cycle N -> gnt0=1 in cycle N+1 only; rd_addr=2 gives 8'hA5 from N+2 and the old value in N+1.
- Contention after reset: req0 and req1 raised in the same cycle (addr0=1/8'h11, addr1=3/8'h33) -> gnt0 first, gnt1 the next cycle, busy high for two cycles; bank[1]=8'h11, bank[3]=8'h33.
- Fairness: both reqs held high for 8 cycles -> gnt alternates 0,1,0,1… with no IDLE cycles and no double grant to either requester.
- Single held request: req1 held high for 6 cycles, req0=0 -> gnt1 pattern 1,0,1,0 (IDLE between grants); each grant writes the data1 latched at that transition.
- Same-address back-to-back: req0 to addr 0 = 8'hF0 granted, then req1 to addr 0 = 8'h0F -> final bank[0]=8'h0F, with 8'hF0 visible for exactly one cycle.
